// File: rtl/alu_sel_pkg.sv
`default_nettype none
// alu_sel_pkg: shared select encodings, default geometry and payload sizing
// for the execute-stage result selector.
package alu_sel_pkg;

  localparam int SEL_AND  = 0;
  localparam int SEL_SLTI = 1;
  localparam int SEL_OR   = 2;
  localparam int SEL_XOR  = 3;
  localparam int SEL_ADD  = 4;
  localparam int SEL_ADDI = 5;
  localparam int SEL_SLL  = 6;
  localparam int SEL_SRA  = 7;
  localparam int SEL_SUB  = 8;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 9;

  // Payload layout, MSB first: {data, zero, negative, sel_err}
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 zero;
    logic                 negative;
    logic                 sel_err;
  } alu_payload_t;

  function automatic int payload_width(input int width);
    return width + 3;
  endfunction

  // Buffer occupancy encoded as {main_valid, skid_valid}
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b10,
    BUF_FULL  = 2'b11
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_sel_pipe_skid_buf.sv
`default_nettype none
// skid_buf: two-register valid/ready buffer; ready is a decode of registered
// occupancy so it never sees the downstream ready combinationally.
module skid_buf
  import alu_sel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state, state_nx;
  logic [W-1:0] main_data, skid_data;
  logic         accept;
  logic         load_main, main_from_skid, load_skid;

  assign in_ready  = (state != BUF_FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = state[1];
  assign out_data  = main_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nx  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (out_ready) begin
          if (accept) load_main = 1'b1;
          else        state_nx  = BUF_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nx  = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (out_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nx       = BUF_ONE;
        end
      end
      default: state_nx = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) main_data <= main_from_skid ? skid_data : in_data;
      if (load_skid) skid_data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_sel_pipe.sv
`default_nettype none
// alu_result_sel_pipe: selects one functional-unit result, attaches
// zero/negative/select-error flags and registers it behind a skid buffer.
module alu_result_sel_pipe
  import alu_sel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [SEL_W-1:0]        S,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        Dalja,
  output logic                    Zero,
  output logic                    Negative,
  output logic                    SelErr,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [CNT_W-1:0]        ErrCount
);

  localparam int PAY_W = payload_width(WIDTH);

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             sel_err;
  logic [PAY_W-1:0] in_payload, out_payload;
  logic [CNT_W-1:0] err_cnt;

  // Compare against every legal index so an out-of-range select simply
  // finds no match and leaves the data at zero.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (S == SEL_W'(k)) begin
        sel_data = In[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign sel_err    = !sel_hit;
  assign in_payload = {sel_data, (sel_data == '0), sel_data[WIDTH-1], sel_err};

  skid_buf #(
    .W (PAY_W)
  ) u_skid_buf (
    .clk       (Clock),
    .rst       (Reset),
    .in_data   (in_payload),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .out_data  (out_payload),
    .out_valid (OutValid),
    .out_ready (OutReady)
  );

  assign {Dalja, Zero, Negative, SelErr} = out_payload;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_cnt <= '0;
    end else if (InValid && InReady && sel_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign ErrCount = err_cnt;

endmodule
`default_nettype wire
